// File: rtl/sqz_pkg.sv
// Shared types and the requantisation helper for the convolution sequencer.
package sqz_pkg;

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} seq_state_t;

  localparam int ACC_W_DEF = 20;

  // Arithmetic shift then clamp to the unsigned 7-bit range; negative results become 0.
  function automatic logic [7:0] relu_q8(input logic signed [31:0] acc, input logic [3:0] shift);
    logic signed [31:0] s;
    s = acc >>> shift;
    if (s < 0)
      return 8'd0;
    else if (s > 32'sd127)
      return 8'd127;
    else
      return s[7:0];
  endfunction

endpackage

// File: rtl/mac_s8.sv
// Signed 8x8 multiply with an accumulator that restarts on the first tap of a pixel.
module mac_s8 #(
  parameter int ACC_W = 20
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    en_i,
  input  logic                    first_i,
  input  logic signed [7:0]       a_i,
  input  logic signed [7:0]       b_i,
  output logic signed [ACC_W-1:0] acc_d_o
);

  logic signed [15:0]      prod;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  assign prod    = a_i * b_i;
  assign acc_d   = first_i ? ACC_W'(prod) : acc_q + ACC_W'(prod);
  assign acc_d_o = acc_d;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)
      acc_q <= '0;
    else if (en_i)
      acc_q <= acc_d;
  end

endmodule

// File: rtl/conv_sequencer.sv
// Walks one stride-1, unpadded KxK convolution over the RAMs: one tap per MAC cycle,
// then a single WRITE cycle per output pixel carrying the ReLU/requantised result.
module conv_sequencer
  import sqz_pkg::*;
#(
  parameter int IN_DIM = 4,
  parameter int K      = 3,
  parameter int W_BASE = 0,
  parameter int SHIFT  = 0,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [9:0]  in_addr,
  input  logic [7:0]  in_data,
  output logic [9:0]  w_addr,
  input  logic [7:0]  w_data,
  output logic [11:0] out_addr,
  output logic [7:0]  out_data,
  output logic        out_ld
);

  localparam int OUT_DIM = IN_DIM - K + 1;
  localparam int CW = 6;
  localparam logic [CW-1:0] KM1 = CW'(K - 1);
  localparam logic [CW-1:0] OM1 = CW'(OUT_DIM - 1);
  localparam logic [3:0]    SH  = 4'(SHIFT);

  if (IN_DIM * IN_DIM > 1024 || OUT_DIM * OUT_DIM > 4096 || W_BASE + K * K > 1024 ||
      K > IN_DIM || K < 1 || ACC_W > 32 || SHIFT < 0 || SHIFT > 15) begin : g_param_err
    $error("conv_sequencer: illegal parameter combination");
  end

  seq_state_t        state_q;
  logic [CW-1:0]     orow_q, ocol_q, kr_q, kc_q;
  logic              busy_q, done_q, out_ld_q;
  logic [11:0]       out_addr_q;
  logic [7:0]        out_data_q;
  logic              mac_en, first_tap, last_tap, last_pix;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [31:0]      acc_ext;

  assign mac_en    = (state_q == MAC);
  assign first_tap = (kr_q == '0) && (kc_q == '0);
  assign last_tap  = (kr_q == KM1) && (kc_q == KM1);
  assign last_pix  = (orow_q == OM1) && (ocol_q == OM1);
  assign acc_ext   = 32'(acc_d);

  // Addresses come straight from the counters so RAM data returns within the same tap.
  assign in_addr = mac_en ? 10'((32'(orow_q) + 32'(kr_q)) * IN_DIM + 32'(ocol_q) + 32'(kc_q)) : '0;
  assign w_addr  = mac_en ? 10'(W_BASE + 32'(kr_q) * K + 32'(kc_q)) : '0;

  mac_s8 #(.ACC_W(ACC_W)) u_mac (
    .clk_i   (Clk),
    .rst_n_i (reset),
    .en_i    (mac_en),
    .first_i (first_tap),
    .a_i     ($signed(in_data)),
    .b_i     ($signed(w_data)),
    .acc_d_o (acc_d)
  );

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      orow_q     <= '0;
      ocol_q     <= '0;
      kr_q       <= '0;
      kc_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      out_ld_q   <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
    end else begin
      done_q     <= 1'b0;
      out_ld_q   <= 1'b0;
      out_data_q <= '0;
      out_addr_q <= '0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= MAC;
            busy_q  <= 1'b1;
            orow_q  <= '0;
            ocol_q  <= '0;
            kr_q    <= '0;
            kc_q    <= '0;
          end
        end
        MAC: begin
          busy_q <= 1'b1;
          if (last_tap) begin
            // Result is registered from the final accumulate so WRITE sees it immediately.
            state_q    <= WRITE;
            kr_q       <= '0;
            kc_q       <= '0;
            out_ld_q   <= 1'b1;
            out_data_q <= relu_q8(acc_ext, SH);
            out_addr_q <= 12'(32'(orow_q) * OUT_DIM + 32'(ocol_q));
          end else if (kc_q == KM1) begin
            kc_q <= '0;
            kr_q <= kr_q + 1'b1;
          end else begin
            kc_q <= kc_q + 1'b1;
          end
        end
        WRITE: begin
          if (last_pix) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            orow_q  <= '0;
            ocol_q  <= '0;
          end else begin
            state_q <= MAC;
            busy_q  <= 1'b1;
            if (ocol_q == OM1) begin
              ocol_q <= '0;
              orow_q <= orow_q + 1'b1;
            end else begin
              ocol_q <= ocol_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign out_ld   = out_ld_q;
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench: two sequencers (SHIFT=0 and SHIFT=4) share RAM contents and stimulus.
module tb_conv_sequencer;

  logic        clk, reset, start;
  logic        busy0, done0, out_ld0, busy4, done4, out_ld4;
  logic [9:0]  in_addr0, w_addr0, in_addr4, w_addr4;
  logic [7:0]  in_data0, w_data0, in_data4, w_data4;
  logic [11:0] out_addr0, out_addr4;
  logic [7:0]  out_data0, out_data4;

  logic [7:0] in_mem [1024];
  logic [7:0] w_mem  [1024];
  logic [7:0] got0   [4096];
  logic [7:0] got4   [4096];
  int nld0, nld4, ndn0;
  int n_chk, n_fail;

  assign in_data0 = in_mem[in_addr0];
  assign w_data0  = w_mem[w_addr0];
  assign in_data4 = in_mem[in_addr4];
  assign w_data4  = w_mem[w_addr4];

  conv_sequencer #(.IN_DIM(4), .K(3), .W_BASE(0), .SHIFT(0), .ACC_W(20)) u_dut0 (
    .Clk(clk), .reset(reset), .start(start), .busy(busy0), .done(done0),
    .in_addr(in_addr0), .in_data(in_data0), .w_addr(w_addr0), .w_data(w_data0),
    .out_addr(out_addr0), .out_data(out_data0), .out_ld(out_ld0));

  conv_sequencer #(.IN_DIM(4), .K(3), .W_BASE(0), .SHIFT(4), .ACC_W(20)) u_dut4 (
    .Clk(clk), .reset(reset), .start(start), .busy(busy4), .done(done4),
    .in_addr(in_addr4), .in_data(in_data4), .w_addr(w_addr4), .w_data(w_data4),
    .out_addr(out_addr4), .out_data(out_data4), .out_ld(out_ld4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_ld0) begin got0[out_addr0] = out_data0; nld0++; end
    if (out_ld4) begin got4[out_addr4] = out_data4; nld4++; end
    if (done0) ndn0++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_mem(input bit ramp, input logic [7:0] iv, input logic [7:0] wv);
    for (int i = 0; i < 16; i++) in_mem[i] = ramp ? 8'(i) : iv;
    for (int i = 0; i < 9; i++) w_mem[i] = wv;
  endtask

  // One layer; done must appear right after the 40th edge following the start-sampling
  // edge t (the cycle ending at edge t+41), busy from edge t, 4 writes, one done.
  task automatic run_layer(input string tag, input bit hold, input bit trace);
    int c, b0, b4, bd;
    bit seen;
    b0 = nld0; b4 = nld4; bd = ndn0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    chk({tag, "_busy"}, busy0, 1);
    if (trace) begin
      chk("tap0_in_addr", in_addr0, 0);
      chk("tap0_w_addr", w_addr0, 0);
    end
    c = 0; seen = 0;
    while (!seen && c < 200) begin
      @(posedge clk); #1;
      c++;
      if (trace && c < 9) begin
        chk($sformatf("tap%0d_in_addr", c), in_addr0, (c / 3) * 4 + (c % 3));
        chk($sformatf("tap%0d_w_addr", c), w_addr0, c);
      end
      if (done0) seen = 1;
    end
    if (hold) start = 1'b0;
    chk({tag, "_lat"}, seen ? c : -1, 40);
    chk({tag, "_done4"}, done4, 1);
    chk({tag, "_busy_in_done"}, busy0, 0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done0, 0);
    repeat (20) @(posedge clk);
    #1;
    chk({tag, "_nwrites0"}, nld0 - b0, 4);
    chk({tag, "_nwrites4"}, nld4 - b4, 4);
    chk({tag, "_ndone"}, ndn0 - bd, 1);
    chk({tag, "_idle_busy"}, busy0, 0);
  endtask

  task automatic chk_outs(input string tag, input int e0 [4], input int e4 [4]);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_out0[%0d]", tag, i), got0[i], e0[i]);
      chk($sformatf("%s_out4[%0d]", tag, i), got4[i], e4[i]);
    end
  endtask

  initial begin
    int b0, bd;
    n_chk = 0; n_fail = 0; nld0 = 0; nld4 = 0; ndn0 = 0;
    for (int i = 0; i < 1024; i++) begin in_mem[i] = '0; w_mem[i] = '0; end
    reset = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_out_ld", out_ld0, 0);
    chk("rst_in_addr", in_addr0, 0);
    chk("rst_w_addr", w_addr0, 0);
    chk("rst_out_addr", out_addr0, 0);
    chk("rst_out_data", out_data0, 0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);

    // all ones: 9 per pixel; 9>>>4 = 0
    set_mem(1'b0, 8'd1, 8'd1);
    run_layer("t1", 1'b0, 1'b0);
    chk_outs("t1", '{9, 9, 9, 9}, '{0, 0, 0, 0});

    // ramp input, unit weights, with per-tap address trace
    set_mem(1'b1, 8'd0, 8'd1);
    run_layer("t2", 1'b0, 1'b1);
    chk_outs("t2", '{45, 54, 81, 90}, '{2, 3, 5, 5});

    // saturation and ReLU
    set_mem(1'b0, 8'd127, 8'd127);
    run_layer("t3a", 1'b0, 1'b0);
    chk_outs("t3a", '{127, 127, 127, 127}, '{127, 127, 127, 127});
    set_mem(1'b0, 8'd5, 8'hFF);
    run_layer("t3b", 1'b0, 1'b0);
    chk_outs("t3b", '{0, 0, 0, 0}, '{0, 0, 0, 0});

    // acc=144: shifted by 4 gives 9, unshifted clamps
    set_mem(1'b0, 8'd16, 8'd1);
    run_layer("t4", 1'b0, 1'b0);
    chk_outs("t4", '{127, 127, 127, 127}, '{9, 9, 9, 9});

    // start held high through the whole layer
    set_mem(1'b0, 8'd2, 8'd1);
    run_layer("t5", 1'b1, 1'b0);
    chk_outs("t5", '{18, 18, 18, 18}, '{1, 1, 1, 1});

    // reset mid-layer at edge t+15, then restart
    set_mem(1'b0, 8'd1, 8'd1);
    b0 = nld0; bd = ndn0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("t6_rst_busy", busy0, 0);
    chk("t6_rst_out_ld", out_ld0, 0);
    chk("t6_rst_in_addr", in_addr0, 0);
    chk("t6_rst_w_addr", w_addr0, 0);
    chk("t6_rst_out_data", out_data0, 0);
    chk("t6_rst_done", done0, 0);
    chk("t6_writes_before", nld0 - b0, 1);
    b0 = nld0;
    @(negedge clk); reset = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("t6_no_writes_after", nld0 - b0, 0);
    chk("t6_no_done", ndn0 - bd, 0);
    chk("t6_idle_busy", busy0, 0);
    run_layer("t6r", 1'b0, 1'b0);
    chk_outs("t6r", '{9, 9, 9, 9}, '{0, 0, 0, 0});

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
